fp32_norm_shift: RTL and testbench
==================================

FP32_NORM_SHIFT -- requirements
Module: fp32_norm_shift

Interface
REQ-001 Parameters: none; widths are fixed to FP32 (8-bit exponent, 24-bit significand plus 1 carry bit).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  upstream operand valid.
REQ-005 o_ready  output  1  block can accept an operand this cycle.
REQ-006 i_sign  input  1  operand sign, passed through unchanged.
REQ-007 i_exp  input  8  biased exponent of unnormalized operand.
REQ-008 i_mant  input  25  unnormalized significand; bit 24 carry, bit 23 hidden-bit position.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  downstream accepts result.
REQ-011 o_sign, o_exp[7:0], o_frac[22:0]  output  normalized FP32 fields.
REQ-012 o_zero, o_underflow, o_overflow  output  1 each  result flags, valid with o_valid.

Function
REQ-013 Transfer in occurs when i_valid & o_ready; transfer out occurs when o_valid & i_ready.
REQ-014 Two-stage pipeline; S1 registers leading-zero count and operand, S2 registers the shifted result; latency is exactly 2 cycles with i_ready held high.
REQ-015 S2 loads when S2 is empty or its result is consumed; S1 loads when S1 is empty or S1 moves into S2; o_ready = ~s1_valid | s1_advance (combinational, no dependence on i_valid).
REQ-016 Throughput is one operand per cycle while i_ready is high; with i_ready low, two operands are held and none is lost or duplicated.
REQ-017 o_valid and outputs hold stable while o_valid & ~i_ready.
REQ-018 Carry case (i_mant[24]=1): shift right 1, truncate dropped LSB, exp+1; if i_exp+1 >= 255 the result is exp=255, frac=0, o_overflow=1.
REQ-019 Zero case (i_mant=0): exp=0, frac=0, o_zero=1, sign preserved.
REQ-020 Normal case: lz = leading zeros of i_mant[23:0] (0..23); if i_exp > lz, shift left by lz, exp = i_exp - lz.
REQ-021 Subnormal case: if 1 <= i_exp <= lz, shift left by i_exp-1, exp=0, o_underflow=1.
REQ-022 i_exp=0 with nonzero i_mant[23:0] and i_mant[24]=0: no shift, exp=0, o_underflow=1.
REQ-023 o_frac is bits [22:0] of the shifted significand; flags are mutually exclusive.
REQ-024 Subtraction and comparison use 9-bit intermediates; no wrap-around of the exponent is permitted.

Reset
REQ-025 On i_rst assertion, s1_valid, s2_valid, and o_valid clear immediately; o_exp, o_frac, o_sign, and all flags reset to 0.
REQ-026 Reset mid-operation discards in-flight operands; o_ready is 1 in the first cycle after deassertion.

Structure
REQ-027 Shared package fp32_pkg holds EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF, and the field struct/typedef.
REQ-028 One sub-module, fp32_lzd_24b (24-bit leading-one detector producing a 5-bit count plus a valid flag), instantiated in S1; the barrel shifter is inline.

Verification
REQ-029 i_exp=8'h80, i_mant=25'h0800000, i_ready=1 -> two cycles later o_exp=8'h80, o_frac=0, all flags 0.
REQ-030 i_exp=8'h80, i_mant=25'h0000001 -> o_exp=8'h69 (128-23), o_frac=0.
REQ-031 i_exp=8'h03, i_mant=25'h0000100 (lz=15) -> o_exp=0, o_frac=23'h000400 (shift 2), o_underflow=1.
REQ-032 i_exp=8'hFE, i_mant=25'h1000000 -> o_exp=8'hFF, o_frac=0, o_overflow=1.
REQ-033 Stream 4 back-to-back operands and hold i_ready=0 for 3 cycles -> o_ready drops after 2 are accepted; all 4 results emerge in order, unchanged; i_mant=0 case gives o_zero=1.
REQ-034 Assert i_rst while 2 operands are in flight -> o_valid=0 immediately; no stale result appears after deassertion.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, result records and normalization case encoding.
package fp32_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned MANT_W = 25;
   localparam int unsigned LZ_W   = 5;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef struct packed {
      logic zero;
      logic underflow;
      logic overflow;
   } fp32_flags_t;

   // Operand as captured in S1, together with its leading-zero count.
   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
      logic [LZ_W-1:0]   lz;
      logic              nz;
   } s1_op_t;

   typedef enum logic [2:0] {
      NC_NORMAL,
      NC_CARRY,
      NC_OVERFLOW,
      NC_ZERO,
      NC_SUBNORM
   } norm_case_e;

endpackage

// File: rtl/fp32_norm_shift_if.sv
// Operand/result handshake bundle for the FP32 normalization shifter.
interface fp32_norm_shift_if;
   import fp32_pkg::*;

   logic              i_valid;
   logic              o_ready;
   logic              i_sign;
   logic [EXP_W-1:0]  i_exp;
   logic [MANT_W-1:0] i_mant;
   logic              o_valid;
   logic              i_ready;
   logic              o_sign;
   logic [EXP_W-1:0]  o_exp;
   logic [FRAC_W-1:0] o_frac;
   logic              o_zero;
   logic              o_underflow;
   logic              o_overflow;

   modport master (
      output i_valid, i_sign, i_exp, i_mant, i_ready,
      input  o_ready, o_valid, o_sign, o_exp, o_frac, o_zero, o_underflow, o_overflow
   );

   modport slave (
      input  i_valid, i_sign, i_exp, i_mant, i_ready,
      output o_ready, o_valid, o_sign, o_exp, o_frac, o_zero, o_underflow, o_overflow
   );

endinterface

// File: rtl/fp32_lzd_24b.sv
// 24-bit leading-one detector: count of zeros above the highest set bit.
module fp32_lzd_24b
   import fp32_pkg::*;
(
   input  logic [23:0]     bits,
   output logic [LZ_W-1:0] count,
   output logic            found
);

   // Ascending scan: the last hit is the most significant one.
   always_comb begin
      count = 5'd24;
      found = 1'b0;
      for (int unsigned i = 0; i < 24; i++) begin
         if (bits[i]) begin
            count = 5'(23 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp32_norm_shift.sv
// Two-stage FP32 normalizer: S1 captures operand + leading-zero count, S2 shifts and flags.
module fp32_norm_shift
   import fp32_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   fp32_norm_shift_if.slave  bus
);

   s1_op_t          s1_op;
   logic            s1_valid;
   logic            s2_valid;
   fp32_t           s2_res;
   fp32_flags_t     s2_flags;
   logic [LZ_W-1:0] lz_count;
   logic            lz_found;
   logic            s2_load;
   logic            s1_advance;
   logic            in_ready;

   fp32_lzd_24b u_lzd (
      .bits  (bus.i_mant[23:0]),
      .count (lz_count),
      .found (lz_found)
   );

   assign s2_load    = ~s2_valid | bus.i_ready;
   assign s1_advance = s1_valid & s2_load;
   assign in_ready   = ~s1_valid | s1_advance;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
      end else if (in_ready) begin
         s1_valid <= bus.i_valid;
         if (bus.i_valid)
            s1_op <= '{sign: bus.i_sign, exp: bus.i_exp, mant: bus.i_mant,
                       lz: lz_count, nz: lz_found};
      end
   end

   norm_case_e        nc;
   logic [EXP_W:0]    exp_inc;
   logic [EXP_W:0]    exp_diff;
   logic [LZ_W-1:0]   shamt;
   logic [FRAC_W-1:0] shifted;
   fp32_t             res;
   fp32_flags_t       flags;

   // exp_diff is 9-bit so "exp > lz" is a sign/zero test with no wrap; exp=0 lands in
   // the subnormal branch with a zero shift.
   always_comb begin
      exp_inc  = {1'b0, s1_op.exp} + 9'd1;
      exp_diff = {1'b0, s1_op.exp} - {4'b0, s1_op.lz};
      if (s1_op.mant[24])
         nc = (exp_inc >= {1'b0, EXP_MAX}) ? NC_OVERFLOW : NC_CARRY;
      else if (!s1_op.nz)
         nc = NC_ZERO;
      else if (!exp_diff[8] && exp_diff != '0)
         nc = NC_NORMAL;
      else
         nc = NC_SUBNORM;

      shamt = '0;
      if (nc == NC_NORMAL)
         shamt = s1_op.lz;
      else if (nc == NC_SUBNORM && s1_op.exp != '0)
         shamt = s1_op.exp[4:0] - 5'd1;
      // Bit 23 never reaches the fraction, so shifting only [22:0] is equivalent.
      shifted = s1_op.mant[22:0] << shamt;

      res.sign = s1_op.sign;
      res.exp  = '0;
      res.frac = '0;
      flags    = '0;
      case (nc)
         NC_CARRY: begin
            res.exp  = exp_inc[7:0];
            res.frac = s1_op.mant[23:1];
         end
         NC_OVERFLOW: begin
            res.exp        = EXP_MAX;
            flags.overflow = 1'b1;
         end
         NC_ZERO:    flags.zero = 1'b1;
         NC_NORMAL: begin
            res.exp  = exp_diff[7:0];
            res.frac = shifted;
         end
         NC_SUBNORM: begin
            res.frac        = shifted;
            flags.underflow = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_res   <= '0;
         s2_flags <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_res   <= res;
            s2_flags <= flags;
         end
      end
   end

   assign bus.o_ready     = in_ready;
   assign bus.o_valid     = s2_valid;
   assign bus.o_sign      = s2_res.sign;
   assign bus.o_exp       = s2_res.exp;
   assign bus.o_frac      = s2_res.frac;
   assign bus.o_zero      = s2_flags.zero;
   assign bus.o_underflow = s2_flags.underflow;
   assign bus.o_overflow  = s2_flags.overflow;

endmodule

// File: tb/tb_fp32_norm_shift.sv
// Directed-vector bench for fp32_norm_shift: single operands, stall/stream and reset flush.
module tb_fp32_norm_shift;

   logic i_clk;
   logic i_rst;
   int   total = 0;
   int   bad   = 0;

   fp32_norm_shift_if bus ();

   fp32_norm_shift dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [7:0]  x_exp;
      logic [22:0] x_frac;
      logic        x_zero;
      logic        x_uf;
      logic        x_ovf;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] actual_res();
      return {29'b0, bus.o_sign, bus.o_exp, bus.o_frac, bus.o_zero, bus.o_underflow, bus.o_overflow};
   endfunction

   function automatic logic [63:0] expected_res(input vec_t v);
      return {29'b0, v.sign, v.x_exp, v.x_frac, v.x_zero, v.x_uf, v.x_ovf};
   endfunction

   task automatic drive(input vec_t v);
      bus.i_valid = 1'b1;
      bus.i_sign  = v.sign;
      bus.i_exp   = v.exp;
      bus.i_mant  = v.mant;
   endtask

   task automatic run_stream(input int hold);
      int          idx [4] = '{0, 4, 1, 2};
      int          in_n = 0;
      int          out_n = 0;
      int          iters = 0;
      logic        have_snap = 1'b0;
      logic [63:0] snap = '0;
      logic        in_fire;
      logic        out_fire;
      for (int cyc = 0; cyc < 40 && out_n < 4; cyc++) begin
         bus.i_ready = (cyc >= hold);
         if (in_n < 4) drive(vecs[idx[in_n]]);
         else bus.i_valid = 1'b0;
         #1;
         if (hold > 0 && cyc == 2) begin
            check("hold_o_ready", 64'(bus.o_ready), 64'd0);
            check("hold_accepted", 64'(in_n), 64'd2);
         end
         if (hold == 0 && in_n < 4) check("tput_o_ready", 64'(bus.o_ready), 64'd1);
         if (have_snap) check("hold_stable", actual_res() | {bus.o_valid, 63'b0}, snap);
         have_snap = bus.o_valid & ~bus.i_ready;
         snap      = actual_res() | {bus.o_valid, 63'b0};
         in_fire   = bus.i_valid & bus.o_ready;
         out_fire  = bus.o_valid & bus.i_ready;
         if (out_fire) begin
            check($sformatf("stream%0d_out%0d", hold, out_n), actual_res(), expected_res(vecs[idx[out_n]]));
            out_n++;
         end
         if (in_fire) in_n++;
         iters++;
         @(posedge i_clk); #1;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      check("stream_count", 64'(out_n), 64'd4);
      check("stream_cycles", 64'(iters), (hold == 0) ? 64'd6 : 64'd7);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int stale;
      vecs[0]  = '{sign:0, exp:8'h80, mant:25'h0800000, x_exp:8'h80, x_frac:23'h000000, x_zero:0, x_uf:0, x_ovf:0};
      vecs[1]  = '{sign:0, exp:8'h80, mant:25'h0000001, x_exp:8'h69, x_frac:23'h000000, x_zero:0, x_uf:0, x_ovf:0};
      vecs[2]  = '{sign:0, exp:8'h03, mant:25'h0000100, x_exp:8'h00, x_frac:23'h000400, x_zero:0, x_uf:1, x_ovf:0};
      vecs[3]  = '{sign:0, exp:8'hFE, mant:25'h1000000, x_exp:8'hFF, x_frac:23'h000000, x_zero:0, x_uf:0, x_ovf:1};
      vecs[4]  = '{sign:1, exp:8'h05, mant:25'h0000000, x_exp:8'h00, x_frac:23'h000000, x_zero:1, x_uf:0, x_ovf:0};
      vecs[5]  = '{sign:0, exp:8'h00, mant:25'h0000123, x_exp:8'h00, x_frac:23'h000123, x_zero:0, x_uf:1, x_ovf:0};
      vecs[6]  = '{sign:0, exp:8'h10, mant:25'h1800001, x_exp:8'h11, x_frac:23'h400000, x_zero:0, x_uf:0, x_ovf:0};
      vecs[7]  = '{sign:1, exp:8'hFF, mant:25'h1000000, x_exp:8'hFF, x_frac:23'h000000, x_zero:0, x_uf:0, x_ovf:1};
      vecs[8]  = '{sign:0, exp:8'h17, mant:25'h0000001, x_exp:8'h00, x_frac:23'h400000, x_zero:0, x_uf:1, x_ovf:0};
      vecs[9]  = '{sign:0, exp:8'h18, mant:25'h0000001, x_exp:8'h01, x_frac:23'h000000, x_zero:0, x_uf:0, x_ovf:0};
      vecs[10] = '{sign:0, exp:8'h01, mant:25'h0000400, x_exp:8'h00, x_frac:23'h000400, x_zero:0, x_uf:1, x_ovf:0};
      vecs[11] = '{sign:0, exp:8'h7F, mant:25'h0FFFFFF, x_exp:8'h7F, x_frac:23'h7FFFFF, x_zero:0, x_uf:0, x_ovf:0};
      vecs[12] = '{sign:1, exp:8'h40, mant:25'h0012345, x_exp:8'h39, x_frac:23'h11A280, x_zero:0, x_uf:0, x_ovf:0};
      vecs[13] = '{sign:0, exp:8'h20, mant:25'h1FFFFFF, x_exp:8'h21, x_frac:23'h7FFFFF, x_zero:0, x_uf:0, x_ovf:0};
      vecs[14] = '{sign:1, exp:8'hFD, mant:25'h1000002, x_exp:8'hFE, x_frac:23'h000001, x_zero:0, x_uf:0, x_ovf:0};

      i_rst       = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_sign  = 1'b0;
      bus.i_exp   = '0;
      bus.i_mant  = '0;
      bus.i_ready = 1'b1;
      #12;
      check("reset_o_valid", 64'(bus.o_valid), 64'd0);
      check("reset_fields", actual_res(), 64'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      #1;
      check("reset_o_ready", 64'(bus.o_ready), 64'd1);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge i_clk); #1;
         bus.i_valid = 1'b0;
         check($sformatf("vec%0d_lat1", i), 64'(bus.o_valid), 64'd0);
         @(posedge i_clk); #1;
         check($sformatf("vec%0d_valid", i), 64'(bus.o_valid), 64'd1);
         check($sformatf("vec%0d_result", i), actual_res(), expected_res(vecs[i]));
      end
      @(posedge i_clk); #1;

      run_stream(3);
      repeat (2) @(posedge i_clk);
      #1;
      run_stream(0);
      repeat (2) @(posedge i_clk);
      #1;

      // Two operands in flight, then an asynchronous reset between clock edges.
      bus.i_ready = 1'b0;
      drive(vecs[0]);
      @(posedge i_clk); #1;
      drive(vecs[3]);
      @(posedge i_clk); #1;
      bus.i_valid = 1'b0;
      check("pre_rst_o_valid", 64'(bus.o_valid), 64'd1);
      #2;
      i_rst = 1'b1;
      #1;
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_fields", actual_res(), 64'd0);
      check("rst_o_ready", 64'(bus.o_ready), 64'd1);
      @(posedge i_clk); #1;
      i_rst       = 1'b0;
      bus.i_ready = 1'b1;
      #1;
      check("post_rst_o_ready", 64'(bus.o_ready), 64'd1);
      stale = 0;
      repeat (6) begin
         @(posedge i_clk); #1;
         if (bus.o_valid) stale++;
      end
      check("no_stale_result", 64'(stale), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
